// File: rtl/muldiv_unit_pkg.sv
// ============================================================================
// Module      : muldiv_unit_pkg
// Description : Shared core definitions for the decoder and the RV32M
//               mul/div unit: funct3 encodings, FSM state codes, sign helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package muldiv_unit_pkg;

   typedef logic [2:0] funct3_t;

   localparam funct3_t c_OP_MUL    = 3'd0;
   localparam funct3_t c_OP_MULH   = 3'd1;
   localparam funct3_t c_OP_MULHSU = 3'd2;
   localparam funct3_t c_OP_MULHU  = 3'd3;
   localparam funct3_t c_OP_DIV    = 3'd4;
   localparam funct3_t c_OP_DIVU   = 3'd5;
   localparam funct3_t c_OP_REM    = 3'd6;
   localparam funct3_t c_OP_REMU   = 3'd7;

   localparam logic [1:0] c_ST_IDLE = 2'd0;
   localparam logic [1:0] c_ST_CALC = 2'd1;
   localparam logic [1:0] c_ST_DONE = 2'd2;

   function automatic logic opSignedA(input funct3_t f);
      return (f == c_OP_MULH) || (f == c_OP_MULHSU) || (f == c_OP_DIV) || (f == c_OP_REM);
   endfunction

   function automatic logic opSignedB(input funct3_t f);
      return (f == c_OP_MULH) || (f == c_OP_DIV) || (f == c_OP_REM);
   endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_iter.sv
// ============================================================================
// Module      : muldiv_iter
// Description : Unsigned radix-2 shift-add multiplier / restoring divider,
//               one bit per step. hi:lo holds product, or remainder:quotient.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_iter #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic            step,
   input  logic            isDiv,
   input  logic [XLEN-1:0] opA,
   input  logic [XLEN-1:0] opB,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);

   logic [XLEN-1:0] r_hi, r_lo, r_opB;
   logic [XLEN:0]   w_sum, w_shift, w_diff;

   always_comb begin
      w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opB} : '0);
      w_shift = {r_hi, r_lo[XLEN-1]};
      w_diff  = w_shift - {1'b0, r_opB};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hi  <= '0;
         r_lo  <= '0;
         r_opB <= '0;
      end else if (load) begin
         r_hi  <= '0;
         r_lo  <= opA;
         r_opB <= opB;
      end else if (step) begin
         if (isDiv) begin
            // Restoring step: keep the trial difference only if it did not borrow
            if (!w_diff[XLEN]) begin
               r_hi <= w_diff[XLEN-1:0];
               r_lo <= {r_lo[XLEN-2:0], 1'b1};
            end else begin
               r_hi <= w_shift[XLEN-1:0];
               r_lo <= {r_lo[XLEN-2:0], 1'b0};
            end
         end else begin
            r_hi <= w_sum[XLEN:1];
            r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
         end
      end
   end

   assign hi = r_hi;
   assign lo = r_lo;

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// Module      : muldiv_unit
// Description : RV32M multiply/divide unit with stall handshake. Optional
//               single-cycle multiply when MULDIV_FAST_MUL_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

import muldiv_unit_pkg::*;

module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            kill,
   output logic            stall_req,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int c_CNT_W = $clog2(XLEN);
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(XLEN - 1);

   logic [1:0]          r_state, w_nextState;
   logic [c_CNT_W-1:0]  r_count;
   logic [2:0]          r_op;
   logic                r_aNeg, r_bNeg, r_bZero;
   logic                w_accept, w_step, w_fastMul, w_aNeg, w_bNeg;
   logic [XLEN-1:0]     w_magA, w_magB, w_hi, w_lo, w_quot, w_rem, w_sel;
   logic [2*XLEN-1:0]   w_prodMag, w_prod;

   always_comb begin
      w_aNeg   = opSignedA(op) && a[XLEN-1];
      w_bNeg   = opSignedB(op) && b[XLEN-1];
      w_magA   = w_aNeg ? -a : a;
      w_magB   = w_bNeg ? -b : b;
      w_accept = (r_state == c_ST_IDLE) && start && !kill;
      w_step   = (r_state == c_ST_CALC) && !kill;
   end

`ifdef MULDIV_FAST_MUL_EN
   logic signed [XLEN:0]     w_fastA, w_fastB;
   logic signed [2*XLEN+1:0] w_fastFull;
   logic [2*XLEN-1:0]        r_fastProd;

   always_comb begin
      w_fastA    = $signed({opSignedA(op) & a[XLEN-1], a});
      w_fastB    = $signed({opSignedB(op) & b[XLEN-1], b});
      w_fastFull = w_fastA * w_fastB;
      w_fastMul  = !op[2];
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_fastProd <= '0;
      else if (w_accept)
         r_fastProd <= w_fastFull[2*XLEN-1:0];
   end
`else
   assign w_fastMul = 1'b0;
`endif

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         c_ST_IDLE: if (w_accept) w_nextState = w_fastMul ? c_ST_DONE : c_ST_CALC;
         c_ST_CALC: begin
            if (kill)
               w_nextState = c_ST_IDLE;
            else if (r_count == c_CNT_LAST)
               w_nextState = c_ST_DONE;
         end
         default:   w_nextState = c_ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= c_ST_IDLE;
         r_count <= '0;
         r_op    <= '0;
         r_aNeg  <= 1'b0;
         r_bNeg  <= 1'b0;
         r_bZero <= 1'b0;
      end else begin
         r_state <= w_nextState;
         if (w_accept) begin
            r_op    <= op;
            r_aNeg  <= w_aNeg;
            r_bNeg  <= w_bNeg;
            r_bZero <= (b == '0);
         end
         if (w_step && (r_count != c_CNT_LAST))
            r_count <= r_count + c_CNT_W'(1);
         else
            r_count <= '0;
      end
   end

   muldiv_iter #(.XLEN(XLEN)) u_iter (
      .clk   (clk),
      .rst   (rst),
      .load  (w_accept),
      .step  (w_step),
      .isDiv (r_op[2]),
      .opA   (w_magA),
      .opB   (w_magB),
      .hi    (w_hi),
      .lo    (w_lo)
   );

   // Datapath works on magnitudes; signs are restored here. 0x80000000/-1
   // falls out naturally since negating 0x80000000 yields itself.
   always_comb begin
      w_prodMag = {w_hi, w_lo};
      w_prod    = (r_aNeg ^ r_bNeg) ? -w_prodMag : w_prodMag;
`ifdef MULDIV_FAST_MUL_EN
      if (!r_op[2]) w_prod = r_fastProd;
`endif
      w_quot = r_bZero ? '1 : ((r_aNeg ^ r_bNeg) ? -w_lo : w_lo);
      w_rem  = r_aNeg ? -w_hi : w_hi;
      case (r_op)
         c_OP_MUL:                            w_sel = w_prod[XLEN-1:0];
         c_OP_MULH, c_OP_MULHSU, c_OP_MULHU:  w_sel = w_prod[2*XLEN-1:XLEN];
         c_OP_DIV, c_OP_DIVU:                 w_sel = w_quot;
         c_OP_REM, c_OP_REMU:                 w_sel = w_rem;
         default:                             w_sel = '0;
      endcase
      done      = (r_state == c_ST_DONE) && !kill && !rst;
      stall_req = !rst && (w_accept || (r_state == c_ST_CALC));
      result    = done ? w_sel : '0;
   end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Directed self-checking bench for muldiv_unit; honours
//               MULDIV_FAST_MUL_EN for multiply latency.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_unit;

   localparam logic [2:0] T_MUL = 3'd0, T_MULH = 3'd1, T_MULHSU = 3'd2, T_MULHU = 3'd3;
   localparam logic [2:0] T_DIV = 3'd4, T_DIVU = 3'd5, T_REM = 3'd6, T_REMU = 3'd7;
`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 33;
`endif
   localparam int DIV_LAT = 33;

   logic        clk = 1'b0;
   logic        rst, start, kill;
   logic [2:0]  op;
   logic [31:0] a, b;
   logic        stall_req, done;
   logic [31:0] result;

   int nChecks = 0;
   int nFails  = 0;

   always #5 clk = ~clk;

   muldiv_unit #(.XLEN(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .op        (op),
      .a         (a),
      .b         (b),
      .kill      (kill),
      .stall_req (stall_req),
      .done      (done),
      .result    (result)
   );

   task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] res, output int lat, output bit stallOk,
                         output logic stallAtDone);
      @(negedge clk);
      op = o; a = x; b = y; start = 1'b1; kill = 1'b0;
      #1;
      stallOk = (stall_req === 1'b1);
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      while (done !== 1'b1 && lat < 100) begin
         if (stall_req !== 1'b1) stallOk = 1'b0;
         @(negedge clk);
         lat++;
      end
      res = result;
      stallAtDone = stall_req;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; kill = 1'b0; op = T_DIV; a = 32'd9; b = 32'd2;
      repeat (2) @(negedge clk);
      nChecks++; if (stall_req !== 1'b0) begin nFails++; $display("FAIL reset_stall got %b want 0", stall_req); end
      nChecks++; if (done !== 1'b0) begin nFails++; $display("FAIL reset_done got %b want 0", done); end
      nChecks++; if (result !== 32'h0) begin nFails++; $display("FAIL reset_result got %h want 0", result); end
      start = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_mul();
      logic [31:0] r; int lat; bit sOk; logic sDone;
      run_op(T_MUL, 32'd7, 32'hFFFFFFFD, r, lat, sOk, sDone);
      nChecks++; if (r !== 32'hFFFFFFEB) begin nFails++; $display("FAIL mul_result got %h want ffffffeb", r); end
      nChecks++; if (lat !== MUL_LAT) begin nFails++; $display("FAIL mul_latency got %0d want %0d", lat, MUL_LAT); end
      nChecks++; if (sOk !== 1'b1) begin nFails++; $display("FAIL mul_stall_before_done got %b want 1", sOk); end
      nChecks++; if (sDone !== 1'b0) begin nFails++; $display("FAIL mul_stall_at_done got %b want 0", sDone); end
   endtask

   task automatic test_mulh();
      logic [31:0] r; int lat; bit sOk; logic sDone;
      run_op(T_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, r, lat, sOk, sDone);
      nChecks++; if (r !== 32'hFFFFFFFE) begin nFails++; $display("FAIL mulhu got %h want fffffffe", r); end
      run_op(T_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, r, lat, sOk, sDone);
      nChecks++; if (r !== 32'h00000000) begin nFails++; $display("FAIL mulh got %h want 00000000", r); end
      run_op(T_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, r, lat, sOk, sDone);
      nChecks++; if (r !== 32'hFFFFFFFF) begin nFails++; $display("FAIL mulhsu got %h want ffffffff", r); end
   endtask

   task automatic test_div();
      logic [31:0] r; int lat; bit sOk; logic sDone;
      run_op(T_DIV, 32'hFFFFFFF9, 32'd2, r, lat, sOk, sDone);
      nChecks++; if (r !== 32'hFFFFFFFD) begin nFails++; $display("FAIL div_neg got %h want fffffffd", r); end
      nChecks++; if (lat !== DIV_LAT) begin nFails++; $display("FAIL div_latency got %0d want %0d", lat, DIV_LAT); end
      run_op(T_REM, 32'hFFFFFFF9, 32'd2, r, lat, sOk, sDone);
      nChecks++; if (r !== 32'hFFFFFFFF) begin nFails++; $display("FAIL rem_neg got %h want ffffffff", r); end
      run_op(T_DIVU, 32'd100, 32'd7, r, lat, sOk, sDone);
      nChecks++; if (r !== 32'd14) begin nFails++; $display("FAIL divu got %h want 0000000e", r); end
      run_op(T_REMU, 32'd100, 32'd7, r, lat, sOk, sDone);
      nChecks++; if (r !== 32'd2) begin nFails++; $display("FAIL remu got %h want 00000002", r); end
   endtask

   task automatic test_div_special();
      logic [31:0] r; int lat; bit sOk; logic sDone;
      run_op(T_DIV, 32'd5, 32'd0, r, lat, sOk, sDone);
      nChecks++; if (r !== 32'hFFFFFFFF) begin nFails++; $display("FAIL div_by_zero got %h want ffffffff", r); end
      nChecks++; if (lat !== DIV_LAT) begin nFails++; $display("FAIL div_by_zero_latency got %0d want %0d", lat, DIV_LAT); end
      run_op(T_REMU, 32'd5, 32'd0, r, lat, sOk, sDone);
      nChecks++; if (r !== 32'd5) begin nFails++; $display("FAIL remu_by_zero got %h want 00000005", r); end
      run_op(T_REM, 32'hFFFFFFF9, 32'd0, r, lat, sOk, sDone);
      nChecks++; if (r !== 32'hFFFFFFF9) begin nFails++; $display("FAIL rem_neg_by_zero got %h want fffffff9", r); end
      run_op(T_DIV, 32'h80000000, 32'hFFFFFFFF, r, lat, sOk, sDone);
      nChecks++; if (r !== 32'h80000000) begin nFails++; $display("FAIL div_overflow got %h want 80000000", r); end
      run_op(T_REM, 32'h80000000, 32'hFFFFFFFF, r, lat, sOk, sDone);
      nChecks++; if (r !== 32'h0) begin nFails++; $display("FAIL rem_overflow got %h want 00000000", r); end
   endtask

   task automatic test_kill();
      logic [31:0] r; int lat; bit sOk; logic sDone; int nDone;
      @(negedge clk);
      op = T_DIVU; a = 32'd100; b = 32'd7; start = 1'b1; kill = 1'b0;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      nChecks++; if (stall_req !== 1'b1) begin nFails++; $display("FAIL kill_calc_stall got %b want 1", stall_req); end
      nChecks++; if (result !== 32'h0) begin nFails++; $display("FAIL kill_calc_result got %h want 0", result); end
      kill = 1'b1;
      @(negedge clk);
      nChecks++; if (stall_req !== 1'b0) begin nFails++; $display("FAIL kill_next_stall got %b want 0", stall_req); end
      nChecks++; if (done !== 1'b0) begin nFails++; $display("FAIL kill_next_done got %b want 0", done); end
      kill = 1'b0;
      nDone = 0;
      repeat (40) begin
         @(negedge clk);
         if (done === 1'b1) nDone++;
      end
      nChecks++; if (nDone !== 0) begin nFails++; $display("FAIL kill_no_done got %0d pulses want 0", nDone); end
      run_op(T_MUL, 32'd7, 32'hFFFFFFFD, r, lat, sOk, sDone);
      nChecks++; if (r !== 32'hFFFFFFEB) begin nFails++; $display("FAIL kill_restart_result got %h want ffffffeb", r); end
      nChecks++; if (lat !== MUL_LAT) begin nFails++; $display("FAIL kill_restart_latency got %0d want %0d", lat, MUL_LAT); end
   endtask

   task automatic test_reset_mid();
      int nDone;
      @(negedge clk);
      op = T_DIV; a = 32'h12345678; b = 32'd3; start = 1'b1; kill = 1'b0;
      @(negedge clk);
      start = 1'b0;
      repeat (20) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      nChecks++; if (stall_req !== 1'b0) begin nFails++; $display("FAIL rst_mid_stall got %b want 0", stall_req); end
      nChecks++; if (done !== 1'b0) begin nFails++; $display("FAIL rst_mid_done got %b want 0", done); end
      nChecks++; if (result !== 32'h0) begin nFails++; $display("FAIL rst_mid_result got %h want 0", result); end
      rst = 1'b0;
      nDone = 0;
      repeat (40) begin
         @(negedge clk);
         if (done === 1'b1 || stall_req === 1'b1) nDone++;
      end
      nChecks++; if (nDone !== 0) begin nFails++; $display("FAIL rst_mid_quiet got %0d active cycles want 0", nDone); end
   endtask

   task automatic test_start_during_done();
      logic [31:0] r; int lat; bit sOk; logic sDone; int nDone;
      run_op(T_REMU, 32'd100, 32'd7, r, lat, sOk, sDone);
      start = 1'b1;
      nChecks++; if (r !== 32'd2) begin nFails++; $display("FAIL sdd_result got %h want 00000002", r); end
      @(negedge clk);
      nChecks++; if (done !== 1'b0) begin nFails++; $display("FAIL sdd_single_pulse got %b want 0", done); end
      start = 1'b0;
      nDone = 0;
      repeat (40) begin
         @(negedge clk);
         if (done === 1'b1 || stall_req === 1'b1) nDone++;
      end
      nChecks++; if (nDone !== 0) begin nFails++; $display("FAIL sdd_ignored got %0d active cycles want 0", nDone); end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; kill = 1'b0; op = '0; a = '0; b = '0;
      test_reset();
      test_mul();
      test_mulh();
      test_div();
      test_div_special();
      test_kill();
      test_reset_mid();
      test_start_during_done();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

`default_nettype wire
